// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the shift-add multiply/writeback unit.
//   DW        register file word width and operand width
//   AW        register address width
//   MUL_ITERS number of shift-add iterations (one per multiplier bit)
//   mul_state_t FSM state encoding, also exported on the unit's debug port
package mul_pkg;

  localparam int DW        = 8;
  localparam int AW        = 3;
  localparam int MUL_ITERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_wb_unit.sv
// mul_wb_unit: multi-cycle unsigned DW x DW shift-add multiplier that writes its
// 2*DW-bit product back to the register file as two consecutive byte writes
// (low byte to DstLo, then high byte to DstHi).
//
// Ports:
//   Clk      clock, all state updates on posedge
//   Reset    synchronous active-high reset
//   Start    multiply request, only looked at while IDLE
//   OpA/OpB  multiplicand / multiplier (register file read data)
//   DstLo    destination register for product[DW-1:0]
//   DstHi    destination register for product[2*DW-1:DW]
//   Busy     high from the cycle after Start is taken through the WR_HI cycle
//   Done     one-cycle pulse during the WR_HI cycle
//   Wen/Wd/Wdat register file write port (registered)
//   Product  last completed product, held until the next completion
//   DbgState current FSM state, for observation only
//
// Handshake: Start is a request, not a valid/ready pair. It is accepted on any
// posedge where the unit is IDLE (Busy=0) and Reset=0; while Busy=1 Start is
// ignored and nothing is queued. Completion is signalled by the Done pulse,
// which coincides with the second (high byte) register write.
module mul_wb_unit
  import mul_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DW-1:0]     OpA,
  input  logic [DW-1:0]     OpB,
  input  logic [AW-1:0]     DstLo,
  input  logic [AW-1:0]     DstHi,
  output logic              Busy,
  output logic              Done,
  output logic              Wen,
  output logic [AW-1:0]     Wd,
  output logic [DW-1:0]     Wdat,
  output logic [2*DW-1:0]   Product,
  output mul_state_t        DbgState
);

  localparam int PW = 2 * DW;

  mul_state_t          state_q, state_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [DW-1:0]       mplier_q, mplier_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [AW-1:0]       dst_lo_q, dst_lo_d;
  logic [AW-1:0]       dst_hi_q, dst_hi_d;
  logic                wen_q, wen_d;
  logic [AW-1:0]       wd_q, wd_d;
  logic [DW-1:0]       wdat_q, wdat_d;
  logic                done_q, done_d;
  logic [PW-1:0]       product_q, product_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dst_lo_q  <= '0;
      dst_hi_q  <= '0;
      wen_q     <= 1'b0;
      wd_q      <= '0;
      wdat_q    <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dst_lo_q  <= dst_lo_d;
      dst_hi_q  <= dst_hi_d;
      wen_q     <= wen_d;
      wd_q      <= wd_d;
      wdat_q    <= wdat_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dst_lo_d  = dst_lo_q;
    dst_hi_d  = dst_hi_q;
    product_d = product_q;
    wen_d     = 1'b0;
    wd_d      = '0;
    wdat_d    = '0;
    done_d    = 1'b0;

    // Datapath and state transitions.
    case (state_q)
      IDLE: begin
        if (Start) begin
          mcand_d  = {{DW{1'b0}}, OpA};
          mplier_d = OpB;
          dst_lo_d = DstLo;
          dst_hi_d = DstHi;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // The accumulator is as wide as the full product, so it never overflows.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'(MUL_ITERS - 1)) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        state_d = WR_HI;
      end
      WR_HI: begin
        product_d = acc_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The write port is registered, so it is decoded from the state being
    // entered. acc_d is used because the last CALC iteration lands on the
    // same edge that enters WR_LO.
    case (state_d)
      WR_LO: begin
        wen_d  = 1'b1;
        wd_d   = dst_lo_q;
        wdat_d = acc_d[DW-1:0];
      end
      WR_HI: begin
        wen_d  = 1'b1;
        wd_d   = dst_hi_q;
        wdat_d = acc_d[PW-1:DW];
        done_d = 1'b1;
      end
      default: begin
        wen_d = 1'b0;
      end
    endcase
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Wen      = wen_q;
  assign Wd       = wd_q;
  assign Wdat     = wdat_q;
  assign Product  = product_q;
  assign DbgState = state_q;

endmodule
